// File: rtl/fb_port_arbiter_pkg.sv
// Shared framebuffer definitions: default bus geometry and the arbiter's
// flush-sequencing state encoding.
package fb_port_arbiter_pkg;

  localparam int FB_ADDR_WIDTH = 11;
  localparam int FB_DATA_WIDTH = 16;
  localparam int FB_WBUF_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Framebuffer port bundle: pixel-fetch reads, buffered command writes,
// flush handshake and the single shared RAM port.
interface fb_port_arbiter_if
  import fb_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH,
  parameter int WBUF_DEPTH = FB_WBUF_DEPTH
);

  logic                        rd_req;
  logic [ADDR_WIDTH-1:0]       rd_addr;
  logic                        rd_valid;
  logic [DATA_WIDTH-1:0]       rd_data;
  logic                        wr_valid;
  logic [ADDR_WIDTH-1:0]       wr_addr;
  logic [DATA_WIDTH-1:0]       wr_data;
  logic                        wr_ready;
  logic                        flush_req;
  logic                        flush_done;
  logic [ADDR_WIDTH-1:0]       ram_address;
  logic                        ram_write_enable;
  logic                        ram_clk_enable;
  logic [DATA_WIDTH-1:0]       ram_data_out;
  logic [DATA_WIDTH-1:0]       ram_data_in;
  logic [$clog2(WBUF_DEPTH):0] wbuf_level;

  // Arbiter side.
  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, flush_req, ram_data_in,
    output rd_valid, rd_data, wr_ready, flush_done, ram_address,
           ram_write_enable, ram_clk_enable, ram_data_out, wbuf_level
  );

  // Requester / RAM side.
  modport master (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_data, flush_req, ram_data_in,
    input  rd_valid, rd_data, wr_ready, flush_done, ram_address,
           ram_write_enable, ram_clk_enable, ram_data_out, wbuf_level
  );

endinterface

// File: rtl/fb_wbuf_fifo.sv
// Write-buffer FIFO holding {address, data} entries; power-of-two depth so
// the pointers wrap by natural overflow.
module fb_wbuf_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level_next;
  logic             push_ok, pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: level_next gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    level_next = level;
    if (push_ok && !pop_ok)      level_next = level + 1'b1;
    else if (pop_ok && !push_ok) level_next = level - 1'b1;
  end

  // NOTE: entry storage is not reset; the pointers and level alone define what is valid.
  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_next;
      full  <= (level_next == FULL_LVL);
      empty <= (level_next == '0);
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: reads win the RAM port combinationally,
// buffered writes drain on idle cycles, flush drains the buffer on request.
module fb_port_arbiter
  import fb_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH,
  parameter int WBUF_DEPTH = FB_WBUF_DEPTH
) (
  input logic              clk_in,
  input logic              reset,
  fb_port_arbiter_if.slave bus
);

  localparam int LVL_W   = $clog2(WBUF_DEPTH) + 1;
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  if (WBUF_DEPTH < 2 || (WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0) begin : g_depth_check
    $error("WBUF_DEPTH must be a power of two, at least 2");
  end

  fb_state_e             state;
  logic                  fifo_full, fifo_empty;
  logic [LVL_W-1:0]      fifo_level;
  logic [ENTRY_W-1:0]    head_entry;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  push, pop, rd_grant, rd_pipe;

  assign {head_addr, head_data} = head_entry;

  // Reset gates every combinational grant so the port is quiet while held.
  assign rd_grant     = reset && bus.rd_req;
  assign pop          = reset && !bus.rd_req && !fifo_empty;
  assign bus.wr_ready = reset && !fifo_full && (state == ST_RUN);
  assign push         = bus.wr_valid && bus.wr_ready;

  fb_wbuf_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk_in    (clk_in),
    .reset     (reset),
    .push      (push),
    .push_data ({bus.wr_addr, bus.wr_data}),
    .pop       (pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign bus.wbuf_level   = fifo_level;
  assign bus.ram_data_out = head_data;

  always_comb begin
    bus.ram_address      = '0;
    bus.ram_write_enable = 1'b0;
    bus.ram_clk_enable   = 1'b0;
    if (rd_grant) begin
      bus.ram_address    = bus.rd_addr;
      bus.ram_clk_enable = 1'b1;
    end else if (pop) begin
      bus.ram_address      = head_addr;
      bus.ram_write_enable = 1'b1;
      bus.ram_clk_enable   = 1'b1;
    end
  end

  // RAM returns data one cycle after the grant; one more stage registers it out.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      rd_pipe      <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      rd_pipe      <= bus.rd_req;
      bus.rd_valid <= rd_pipe;
      if (rd_pipe) bus.rd_data <= bus.ram_data_in;
    end
  end

  // A write popped this cycle commits at this edge, so an empty buffer in
  // FLUSH means the last write is already in RAM.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state          <= ST_RUN;
      bus.flush_done <= 1'b0;
    end else begin
      bus.flush_done <= 1'b0;
      unique case (state)
        ST_RUN:   if (bus.flush_req) state <= ST_FLUSH;
        ST_FLUSH: if (fifo_empty) begin
                    state          <= ST_DONE;
                    bus.flush_done <= 1'b1;
                  end
        ST_DONE:  state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Randomised bench for fb_port_arbiter: a queue-based reference model of the
// write buffer, read pipeline and flush sequencing against a behavioural RAM.
module tb_fb_port_arbiter;

  localparam int AW    = 11;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  always #5 clk_in = ~clk_in;

  fb_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WBUF_DEPTH(DEPTH)) bus ();

  fb_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WBUF_DEPTH(DEPTH)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  function automatic logic [DW-1:0] init_word(input int a);
    return DW'(a * 37) ^ 16'h5A3C;
  endfunction

  // Behavioural single-port RAM with registered read data.
  logic [DW-1:0] ram    [1 << AW];
  bit            ram_wr [1 << AW];
  logic [DW-1:0] ram_q;
  int            ram_writes;

  always @(posedge clk_in) begin
    if (bus.ram_clk_enable) begin
      if (bus.ram_write_enable) begin
        ram[bus.ram_address]    <= bus.ram_data_out;
        ram_wr[bus.ram_address] <= 1'b1;
        ram_writes              <= ram_writes + 1;
      end else begin
        ram_q <= ram_wr[bus.ram_address] ? ram[bus.ram_address] : init_word(int'(bus.ram_address));
      end
    end
  end
  assign bus.ram_data_in = ram_q;

  // Reference model state.
  logic [DW-1:0] mdl_mem [1 << AW];
  wr_t wq[$];
  rd_t rq[$];
  bit  flushing, done_now, rdata_zero;
  int  cyc, fd_seen;
  int  n_cmp, n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input bit rst_v, input bit rrq, input logic [AW-1:0] ra,
                      input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit fr, output bit acc);
    bit  exp_ready, exp_rv, pop_now, next_done;
    int  lvl;
    wr_t hd;
    reset         = rst_v;
    bus.rd_req    = rrq;
    bus.rd_addr   = ra;
    bus.wr_valid  = wv;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.flush_req = fr;
    @(negedge clk_in);
    lvl       = wq.size();
    exp_ready = rst_v && !flushing && !done_now && (lvl < DEPTH);
    check("wr_ready", bus.wr_ready, exp_ready);
    check("wbuf_level", bus.wbuf_level, lvl);
    check("flush_done", bus.flush_done, done_now);
    if (bus.flush_done === 1'b1) fd_seen++;
    exp_rv = (rq.size() > 0) && (rq[0].due == cyc);
    check("rd_valid", bus.rd_valid, exp_rv);
    if (exp_rv) begin
      check("rd_data", bus.rd_data, rq[0].data);
      void'(rq.pop_front());
    end
    if (rdata_zero) check("rd_data_after_reset", bus.rd_data, 0);
    pop_now = rst_v && !rrq && (lvl > 0);
    if (!rst_v || (!rrq && !pop_now)) begin
      check("ram_clk_enable_idle", bus.ram_clk_enable, 0);
      check("ram_write_enable_idle", bus.ram_write_enable, 0);
    end else if (rrq) begin
      check("ram_clk_enable_rd", bus.ram_clk_enable, 1);
      check("ram_write_enable_rd", bus.ram_write_enable, 0);
      check("ram_address_rd", bus.ram_address, ra);
    end else begin
      check("ram_clk_enable_wr", bus.ram_clk_enable, 1);
      check("ram_write_enable_wr", bus.ram_write_enable, 1);
      check("ram_address_wr", bus.ram_address, wq[0].addr);
      check("ram_data_out_wr", bus.ram_data_out, wq[0].data);
    end

    acc = exp_ready && wv;
    if (!rst_v) begin
      wq.delete();
      rq.delete();
      flushing   = 1'b0;
      done_now   = 1'b0;
      rdata_zero = 1'b1;
    end else begin
      rdata_zero = 1'b0;
      if (rrq) rq.push_back('{cyc + 2, mdl_mem[ra]});
      next_done = flushing && (lvl == 0);
      if (flushing) flushing = (lvl != 0);
      else          flushing = !done_now && fr;
      done_now = next_done;
      if (pop_now) begin
        hd = wq.pop_front();
        mdl_mem[hd.addr] = hd.data;
      end
      if (acc) wq.push_back('{wa, wd});
    end
    cyc++;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1, 0, '0, 0, '0, '0, 0, acc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int k, w0, f0, diffs;
    logic [DW-1:0] got;

    bus.rd_req    = 1'b0;
    bus.rd_addr   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.flush_req = 1'b0;
    for (int a = 0; a < (1 << AW); a++) mdl_mem[a] = init_word(a);
    rdata_zero = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;

    // Reset state, held one more checked cycle, then released.
    step(0, 1, 11'h005, 1, 11'h006, 16'h1234, 1, acc);
    idle(2);

    // Idle writes commit immediately; reads return them two cycles later.
    step(1, 0, '0, 1, 11'h010, 16'hF800, 0, acc);
    check("wr_accept_010", acc, 1);
    step(1, 0, '0, 1, 11'h011, 16'h07E0, 0, acc);
    idle(2);
    step(1, 1, 11'h010, 0, '0, '0, 0, acc);
    step(1, 1, 11'h011, 0, '0, '0, 0, acc);
    idle(3);

    // 64-cycle read burst: 5 writes offered, only 4 fit, none commit until reads stop.
    w0 = ram_writes;
    k  = 0;
    for (int i = 0; i < 64; i++) begin
      step(1, 1, AW'($urandom_range(0, 2047)), k < 5, AW'(32'h100 + k), DW'(32'hA000 + k), 0, acc);
      if (acc) k++;
    end
    check("burst_accepted", k, 4);
    check("burst_ram_writes", ram_writes - w0, 0);
    idle(4);
    check("drain_ram_writes", ram_writes - w0, 4);
    idle(1);

    // Read of an address queued one cycle earlier under read load sees old data.
    step(1, 1, 11'h030, 1, 11'h020, 16'h001F, 0, acc);
    step(1, 1, 11'h020, 0, '0, '0, 0, acc);
    idle(4);

    // Flush with three buffered writes; the repeated flush_req is ignored.
    for (int i = 0; i < 3; i++) step(1, 1, AW'(i), 1, AW'(32'h200 + i), DW'(32'hBEE0 + i), 0, acc);
    f0 = fd_seen;
    step(1, 0, '0, 0, '0, '0, 1, acc);
    step(1, 0, '0, 1, 11'h2FF, 16'hDEAD, 1, acc);
    check("wr_refused_in_flush", acc, 0);
    idle(8);
    check("flush_pulses_3", fd_seen - f0, 1);

    // Flush with an empty buffer.
    f0 = fd_seen;
    step(1, 0, '0, 0, '0, '0, 1, acc);
    idle(4);
    check("flush_pulses_empty", fd_seen - f0, 1);

    // Reset with a full buffer and reads in flight.
    for (int i = 0; i < 5; i++) step(1, 1, AW'(32'h40 + i), 1, AW'(32'h300 + i), DW'(32'hC000 + i), 0, acc);
    w0 = ram_writes;
    step(0, 1, 11'h044, 0, '0, '0, 0, acc);
    idle(4);
    check("no_write_after_reset", ram_writes - w0, 0);

    // Randomised traffic over a small address window to provoke read/write overlap.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 399) != 0, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)),
           $urandom_range(0, 2) != 0, AW'($urandom_range(0, 31)), DW'($urandom),
           $urandom_range(0, 29) == 0, acc);
    end
    idle(8);

    diffs = 0;
    for (int a = 0; a < (1 << AW); a++) begin
      got = ram_wr[a] ? ram[a] : init_word(a);
      if (got !== mdl_mem[a]) diffs++;
    end
    check("ram_image", diffs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, framebuffer word-address width.
REQ-002 Parameter DATA_WIDTH, default 16, framebuffer word width (one rgb565 pixel).
REQ-003 Parameter WBUF_DEPTH, default 4, write-buffer entries; SHALL be a power of two, minimum 2.
REQ-004 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled only on the clk_in rising edge.
REQ-006 rd_req  input  1  read request from pixel fetch, one word per asserted cycle.
REQ-007 rd_addr  input  ADDR_WIDTH  read word address, valid with rd_req.
REQ-008 rd_valid  output  1  rd_data valid strobe.
REQ-009 rd_data  output  DATA_WIDTH  read data.
REQ-010 wr_valid  input  1  write offer from command/UART side.
REQ-011 wr_addr  input  ADDR_WIDTH  write word address.
REQ-012 wr_data  input  DATA_WIDTH  write data.
REQ-013 wr_ready  output  1  write accepted when wr_valid && wr_ready.
REQ-014 flush_req  input  1  single-cycle pulse: drain all buffered writes.
REQ-015 flush_done  output  1  single-cycle pulse: buffer empty, last write committed.
REQ-016 ram_address  output  ADDR_WIDTH  single shared RAM port address.
REQ-017 ram_write_enable  output  1  RAM write strobe.
REQ-018 ram_clk_enable  output  1  RAM port enable.
REQ-019 ram_data_out  output  DATA_WIDTH  data to RAM.
REQ-020 ram_data_in  input  DATA_WIDTH  data from RAM, registered, 1-cycle latency.
REQ-021 wbuf_level  output  $clog2(WBUF_DEPTH)+1  buffered write count.

Function
REQ-022 Each cycle the RAM port SHALL be granted to exactly one of: read, write-drain, idle.
REQ-023 Read SHALL have strict priority: rd_req=1 drives ram_address=rd_addr, ram_clk_enable=1, ram_write_enable=0 the same cycle (combinational grant).
REQ-024 rd_valid SHALL assert exactly 2 cycles after the accepted rd_req, with rd_data registered from ram_data_in; back-to-back reads yield back-to-back rd_valid.
REQ-025 Accepted writes SHALL enter a FIFO of WBUF_DEPTH entries, in order.
REQ-026 On a cycle with rd_req=0 and FIFO non-empty, the head entry SHALL drive the RAM with ram_write_enable=1 and be popped.
REQ-027 wr_ready SHALL equal (FIFO not full) && (state == RUN); push and pop in the same cycle SHALL be allowed and leave wbuf_level unchanged.
REQ-028 Full FIFO: wr_ready=0; simultaneous pop the same cycle SHALL NOT re-enable wr_ready until the next cycle (registered full flag).
REQ-029 Reads SHALL NOT be forwarded from the FIFO; a read of an address pending in the FIFO returns RAM contents (old data).
REQ-030 State machine: RUN -> FLUSH on flush_req; FLUSH -> DONE when FIFO empty and no write in flight; DONE -> RUN after one cycle.
REQ-031 In FLUSH, wr_ready=0 and reads keep priority; in DONE, flush_done=1 for exactly one cycle.
REQ-032 flush_req in RUN with FIFO already empty SHALL produce flush_done on the second following cycle (RUN->FLUSH->DONE).
REQ-033 flush_req while in FLUSH or DONE SHALL be ignored.
REQ-034 FIFO pointers SHALL wrap modulo WBUF_DEPTH; wbuf_level never exceeds WBUF_DEPTH.

Reset
REQ-035 While reset=0: state=RUN, FIFO empty, wbuf_level=0, rd_valid=0, rd_data=0, flush_done=0, wr_ready=0, ram_write_enable=0, ram_clk_enable=0.
REQ-036 Reset mid-flush or mid-read SHALL discard buffered writes and in-flight read strobes; wr_ready=1 the first cycle after reset releases.

Structure
REQ-037 ADDR_WIDTH/DATA_WIDTH defaults and the state encoding (RUN, FLUSH, DONE) SHALL live in the shared framebuffer package.
REQ-038 The write FIFO SHALL be a separate sub-module, fb_wbuf_fifo (push/pop/full/empty/level).

Verification
REQ-039 Writes to 0x010=0xF800, 0x011=0x07E0 with rd_req=0 -> committed next cycles; later reads return 0xF800, 0x07E0 at +2 cycles.
REQ-040 rd_req held 64 cycles while 4 writes offered -> wr_ready drops after 4, zero RAM writes during burst, all 4 drain in cycles 65-68 in order.
REQ-041 Read 0x020 one cycle after write 0x020=0x001F queued under read load -> old value returned (no forwarding).
REQ-042 3 writes buffered, flush_req pulse -> wr_ready=0 until flush_done; flush_done single pulse after 3rd commit; flush_req repeated during FLUSH ignored.
REQ-043 reset=0 asserted with FIFO full and rd_valid pending -> all outputs per REQ-035 next cycle, no RAM write afterwards.
